// File: rtl/pipe_elastic.sv
// pipe_elastic: DEPTH-stage elastic pipeline with halt sideband, flush, sticky hlt and occupancy count.
// Optional one-entry input skid slot with registered in_ready, enabled by defining PIPE_SKID_EN.
module pipe_elastic #(
   parameter int DWIDTH = 16,
   parameter int DEPTH  = 4,
   parameter int CWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] in_data,
   input  logic              in_halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_halt,
   input  logic              flush,
   output logic              hlt,
   output logic [CWIDTH-1:0] occupancy
);

   if (DWIDTH < 1 || DWIDTH > 64) begin : g_bad_dwidth
      $error("pipe_elastic: DWIDTH must be 1..64");
   end
   if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("pipe_elastic: DEPTH must be 1..8");
   end
   if ((1 << CWIDTH) <= DEPTH + 1) begin : g_bad_cwidth
      $error("pipe_elastic: CWIDTH too narrow for DEPTH+1");
   end

   localparam logic [CWIDTH-1:0] OCC_ONE = CWIDTH'(1);

   function automatic logic [CWIDTH-1:0] occ_step(input logic [CWIDTH-1:0] cur,
                                                 input logic              inc,
                                                 input logic              dec);
      logic [CWIDTH-1:0] nxt;
      nxt = cur;
      if (inc && !dec) begin
         nxt = cur + OCC_ONE;
      end else if (dec && !inc) begin
         nxt = cur - OCC_ONE;
      end
      return nxt;
   endfunction

   logic [DEPTH-1:0]  vld_p;
   logic [DEPTH-1:0]  hlt_p;
   logic [DWIDTH-1:0] dat_p [DEPTH];
   logic [DEPTH-1:0]  load;
   logic              chain_full;
   logic              accept;
   logic              xfer_out;
   logic              halt_seen;
   logic              halt_seen_nxt;
   logic              s0_vld_in;
   logic [DWIDTH-1:0] s0_dat_in;
   logic              s0_hlt_in;

   assign accept    = in_valid & in_ready;
   assign out_valid = vld_p[DEPTH-1];
   assign out_data  = dat_p[DEPTH-1];
   assign out_halt  = hlt_p[DEPTH-1];
   assign xfer_out  = out_valid & out_ready;

   assign halt_seen_nxt = ~flush & (halt_seen | (accept & in_halt));

   // A stage may load whenever some stage at or below it is empty, or the tail is draining.
   always_comb begin
      load       = '0;
      chain_full = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         chain_full = 1'b1;
         for (int j = k; j < DEPTH; j++) begin
            chain_full = chain_full & vld_p[j];
         end
         load[k] = ~chain_full | out_ready;
      end
   end

`ifdef PIPE_SKID_EN
   logic              skid_vld;
   logic              skid_vld_nxt;
   logic [DWIDTH-1:0] skid_dat;
   logic              skid_hlt;
   logic              in_ready_r;

   assign in_ready     = in_ready_r & ~flush;
   assign skid_vld_nxt = load[0] ? 1'b0 : (skid_vld | accept);

   // The skid entry always wins stage 0; in_ready is low while it is occupied.
   assign s0_vld_in = skid_vld | accept;
   assign s0_dat_in = skid_vld ? skid_dat : in_data;
   assign s0_hlt_in = skid_vld ? skid_hlt : in_halt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_vld   <= 1'b0;
         skid_dat   <= '0;
         skid_hlt   <= 1'b0;
         in_ready_r <= 1'b1;
      end else if (flush) begin
         skid_vld   <= 1'b0;
         in_ready_r <= 1'b1;
      end else begin
         skid_vld <= skid_vld_nxt;
         if (!load[0] && accept) begin
            skid_dat <= in_data;
            skid_hlt <= in_halt;
         end
         in_ready_r <= ~skid_vld_nxt & ~halt_seen_nxt;
      end
   end
`else
   assign in_ready  = load[0] & ~halt_seen & ~flush;
   assign s0_vld_in = accept;
   assign s0_dat_in = in_data;
   assign s0_hlt_in = in_halt;
`endif

   // Stage 0 takes the input side; stage k takes stage k-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p <= '0;
         hlt_p <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            dat_p[k] <= '0;
         end
      end else begin
         if (load[0]) begin
            vld_p[0] <= s0_vld_in;
            dat_p[0] <= s0_dat_in;
            hlt_p[0] <= s0_hlt_in;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (load[k]) begin
               vld_p[k] <= vld_p[k-1];
               dat_p[k] <= dat_p[k-1];
               hlt_p[k] <= hlt_p[k-1];
            end
         end
         if (flush) begin
            vld_p <= '0;
         end
      end
   end

   // A halt token leaving during a flush cycle still counts as delivered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halt_seen <= 1'b0;
         hlt       <= 1'b0;
         occupancy <= '0;
      end else begin
         halt_seen <= halt_seen_nxt;
         if (xfer_out && out_halt) begin
            hlt <= 1'b1;
         end
         occupancy <= flush ? '0 : occ_step(occupancy, accept, xfer_out);
      end
   end

endmodule

// File: tb/tb_pipe_elastic.sv
// Directed bench for pipe_elastic: reset, streaming, backpressure, flush, halt, async reset, bubbles.
`timescale 1ns/1ps
module tb_pipe_elastic;
   localparam int DW = 16;
`ifdef PIPE_SKID_EN
   localparam int EXP_FULL = 5;
   localparam int EXTRA    = 1;
`else
   localparam int EXP_FULL = 4;
   localparam int EXTRA    = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          in_valid = 1'b0, in_ready, in_halt = 1'b0, out_valid, out_ready = 1'b0;
   logic          out_halt, flush = 1'b0, hlt;
   logic [DW-1:0] in_data = '0, out_data;
   logic [3:0]    occupancy;

   logic          b1_in_valid = 1'b0, b1_in_ready, b1_out_valid, b1_out_ready = 1'b0;
   logic          b1_out_halt, b1_hlt, b1_flush = 1'b0, b1_in_halt = 1'b0;
   logic [DW-1:0] b1_in_data = '0, b1_out_data;
   logic [3:0]    b1_occ;
   logic          b8_in_valid = 1'b0, b8_in_ready, b8_out_valid, b8_out_ready = 1'b0;
   logic          b8_out_halt, b8_hlt, b8_flush = 1'b0, b8_in_halt = 1'b0;
   logic [DW-1:0] b8_in_data = '0, b8_out_data;
   logic [3:0]    b8_occ;

   pipe_elastic #(.DWIDTH(DW), .DEPTH(4), .CWIDTH(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_halt(in_halt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_halt(out_halt), .flush(flush), .hlt(hlt), .occupancy(occupancy));

   pipe_elastic #(.DWIDTH(DW), .DEPTH(1), .CWIDTH(4)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(b1_in_valid), .in_ready(b1_in_ready), .in_data(b1_in_data),
      .in_halt(b1_in_halt), .out_valid(b1_out_valid), .out_ready(b1_out_ready), .out_data(b1_out_data),
      .out_halt(b1_out_halt), .flush(b1_flush), .hlt(b1_hlt), .occupancy(b1_occ));

   pipe_elastic #(.DWIDTH(DW), .DEPTH(8), .CWIDTH(4)) u_d8 (
      .clk(clk), .rst(rst), .in_valid(b8_in_valid), .in_ready(b8_in_ready), .in_data(b8_in_data),
      .in_halt(b8_in_halt), .out_valid(b8_out_valid), .out_ready(b8_out_ready), .out_data(b8_out_data),
      .out_halt(b8_out_halt), .flush(b8_flush), .hlt(b8_hlt), .occupancy(b8_occ));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [DW-1:0] acc_q [$];
   logic [DW-1:0] out_q [$];
   int            out_cyc_q [$];
   logic [DW-1:0] b1_acc_q [$], b1_out_q [$], b8_acc_q [$], b8_out_q [$];
   int            b1_occ_max = 0, b8_occ_max = 0;

   // Handshake recorder: values sampled at the edge are the pre-edge values.
   always @(posedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) acc_q.push_back(in_data);
         if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            out_cyc_q.push_back(cyc);
         end
         if (b1_in_valid && b1_in_ready) b1_acc_q.push_back(b1_in_data);
         if (b1_out_valid && b1_out_ready) b1_out_q.push_back(b1_out_data);
         if (b8_in_valid && b8_in_ready) b8_acc_q.push_back(b8_in_data);
         if (b8_out_valid && b8_out_ready) b8_out_q.push_back(b8_out_data);
         if (int'(b1_occ) > b1_occ_max) b1_occ_max = int'(b1_occ);
         if (int'(b8_occ) > b8_occ_max) b8_occ_max = int'(b8_occ);
      end
      cyc++;
   end

   task automatic clear_q();
      acc_q.delete();
      out_q.delete();
      out_cyc_q.delete();
   endtask

   task automatic feed(input int total, input logic [DW-1:0] base);
      if (acc_q.size() < total) begin
         in_valid = 1'b1;
         in_data  = base + DW'(acc_q.size() + 1);
      end else begin
         in_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
      checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL reset_hlt got %0b want 0", hlt); end
      checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
      checks++; if (out_halt !== 1'b0) begin errors++; $display("FAIL reset_out_halt got %0b want 0", out_halt); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
   endtask

   task automatic test_stream();
      int lat, peak, bad;
      clear_q();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0001; in_halt = 1'b0;
      lat = -1; peak = 0; bad = 0;
      for (int c = 0; c < 60 && out_q.size() < 16; c++) begin
         @(posedge clk);
         #1;
         if (out_valid && lat < 0) lat = c;
         if (int'(occupancy) > peak) peak = int'(occupancy);
         feed(16, 16'h0000);
      end
      checks++; if (lat !== 3) begin errors++; $display("FAIL stream_latency got %0d want 3", lat); end
      checks++; if (out_q.size() !== 16) begin errors++; $display("FAIL stream_count got %0d want 16", out_q.size()); end
      for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 16'(i + 1)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL stream_order got %0d bad want 0 bad", bad); end
      checks++;
      if (out_cyc_q.size() < 16 || out_cyc_q[15] - out_cyc_q[0] !== 15) begin
         errors++; $display("FAIL stream_gapless got %0d transfers want 16 on consecutive edges", out_cyc_q.size());
      end
      checks++; if (peak !== 4) begin errors++; $display("FAIL stream_peak got %0d want 4", peak); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL stream_final_occ got %0d want 0", occupancy); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held;
      int moved, bad;
      clear_q();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0101;
      moved = 0; bad = 0;
      repeat (6) begin @(posedge clk); #1; feed(8, 16'h0100); end
      held = out_data;
      repeat (10) begin
         @(posedge clk); #1; feed(8, 16'h0100);
         if (out_data !== held || out_valid !== 1'b1) moved++;
      end
      checks++; if (int'(occupancy) !== EXP_FULL) begin errors++; $display("FAIL bp_occupancy got %0d want %0d", occupancy, EXP_FULL); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0b want 0", in_ready); end
      checks++; if (out_data !== 16'h0101) begin errors++; $display("FAIL bp_head_data got %h want 0101", out_data); end
      checks++; if (moved !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", moved); end
      checks++; if (acc_q.size() !== EXP_FULL) begin errors++; $display("FAIL bp_accepted got %0d want %0d", acc_q.size(), EXP_FULL); end
      out_ready = 1'b1;
      for (int c = 0; c < 60 && out_q.size() < 8; c++) begin
         @(posedge clk); #1; feed(8, 16'h0100);
      end
      checks++; if (out_q.size() !== 8) begin errors++; $display("FAIL bp_release_count got %0d want 8", out_q.size()); end
      for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 16'h0101 + 16'(i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_release_order got %0d bad want 0 bad", bad); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL bp_final_occ got %0d want 0", occupancy); end
   endtask

   task automatic test_flush();
      int lit, lat;
      clear_q();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0201;
      lit = 0; lat = -1;
      repeat (3) begin @(posedge clk); #1; feed(3, 16'h0200); end
      flush = 1'b1; in_valid = 1'b1; in_data = 16'h02FF;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b want 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL flush_occupancy got %0d want 0", occupancy); end
      checks++; if (acc_q.size() !== 3) begin errors++; $display("FAIL flush_no_accept got %0d want 3", acc_q.size()); end
      repeat (6) begin @(posedge clk); #1; if (out_valid !== 1'b0) lit++; end
      checks++; if (lit !== 0 || out_q.size() !== 0) begin errors++; $display("FAIL flush_quiet got %0d valid cycles want 0", lit); end
      in_valid = 1'b1; in_data = 16'h02AA;
      for (int c = 0; c < 20 && out_q.size() < 1; c++) begin
         @(posedge clk); #1;
         if (acc_q.size() >= 4) in_valid = 1'b0;
         if (out_valid && lat < 0) lat = c;
      end
      checks++; if (lat !== 3) begin errors++; $display("FAIL flush_refill_latency got %0d want 3", lat); end
      checks++;
      if (out_q.size() !== 1 || out_q[0] !== 16'h02AA) begin
         errors++; $display("FAIL flush_refill_data got %0d tokens want one 02aa", out_q.size());
      end
   endtask

   task automatic test_halt();
      logic pre_hlt;
      int   late_acc;
      clear_q();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h00AA; in_halt = 1'b0;
      pre_hlt = 1'b1;
      for (int c = 0; c < 30 && out_q.size() < 2; c++) begin
         @(posedge clk); #1;
         if (acc_q.size() == 0) begin in_data = 16'h00AA; in_halt = 1'b0; end
         else if (acc_q.size() == 1) begin in_data = 16'h00BB; in_halt = 1'b1; end
         else begin in_data = 16'h00CC; in_halt = 1'b0; end
         if (out_valid && out_halt && out_q.size() < 2) pre_hlt = hlt;
      end
      checks++; if (pre_hlt !== 1'b0) begin errors++; $display("FAIL halt_hlt_before got %0b want 0", pre_hlt); end
      checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL halt_hlt_rise got %0b want 1", hlt); end
      repeat (8) @(posedge clk);
      #1;
      late_acc = acc_q.size();
      checks++; if (late_acc !== 2) begin errors++; $display("FAIL halt_cc_blocked got %0d accepts want 2", late_acc); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got %0b want 0", in_ready); end
      checks++;
      if (out_q.size() !== 2 || out_q[0] !== 16'h00AA || out_q[1] !== 16'h00BB) begin
         errors++; $display("FAIL halt_outputs got %0d tokens want aa,bb", out_q.size());
      end
      in_valid = 1'b0; in_halt = 1'b0; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL halt_sticky got %0b want 1", hlt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL halt_unblock got %0b want 1", in_ready); end
   endtask

   task automatic test_async_reset();
      int lit;
      clear_q();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0301;
      lit = 0;
      repeat (2) begin @(posedge clk); #1; feed(2, 16'h0300); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || occupancy !== 4'd2) begin
         errors++; $display("FAIL areset_pre got valid %0b occ %0d want 1 and 2", out_valid, occupancy);
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %0b want 0", out_valid); end
      checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL areset_occupancy got %0d want 0", occupancy); end
      checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL areset_hlt got %0b want 0", hlt); end
      #2 rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %0b want 1", in_ready); end
      repeat (8) begin @(posedge clk); #1; if (out_valid !== 1'b0) lit++; end
      checks++; if (lit !== 0 || out_q.size() !== 0) begin errors++; $display("FAIL areset_no_residue got %0d valid cycles want 0", lit); end
   endtask

   task automatic test_bubbles();
      int bad1, bad8;
      bad1 = 0; bad8 = 0;
      for (int c = 0; c < 200; c++) begin
         b1_in_valid  = (c % 2 == 0);
         b8_in_valid  = (c % 2 == 0);
         b1_in_data   = 16'h1000 + DW'(b1_acc_q.size() + 1);
         b8_in_data   = 16'h1000 + DW'(b8_acc_q.size() + 1);
         b1_out_ready = 1'($urandom_range(1, 0));
         b8_out_ready = 1'($urandom_range(1, 0));
         @(posedge clk); #1;
      end
      b1_in_valid = 1'b0; b8_in_valid = 1'b0; b1_out_ready = 1'b1; b8_out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      for (int i = 0; i < b1_out_q.size(); i++) if (b1_out_q[i] !== 16'h1000 + 16'(i + 1)) bad1++;
      for (int i = 0; i < b8_out_q.size(); i++) if (b8_out_q[i] !== 16'h1000 + 16'(i + 1)) bad8++;
      checks++; if (b1_acc_q.size() < 20) begin errors++; $display("FAIL bub1_progress got %0d accepts want >=20", b1_acc_q.size()); end
      checks++; if (b8_acc_q.size() < 20) begin errors++; $display("FAIL bub8_progress got %0d accepts want >=20", b8_acc_q.size()); end
      checks++; if (b1_out_q.size() !== b1_acc_q.size()) begin errors++; $display("FAIL bub1_count got %0d want %0d", b1_out_q.size(), b1_acc_q.size()); end
      checks++; if (b8_out_q.size() !== b8_acc_q.size()) begin errors++; $display("FAIL bub8_count got %0d want %0d", b8_out_q.size(), b8_acc_q.size()); end
      checks++; if (bad1 !== 0) begin errors++; $display("FAIL bub1_order got %0d bad want 0", bad1); end
      checks++; if (bad8 !== 0) begin errors++; $display("FAIL bub8_order got %0d bad want 0", bad8); end
      checks++; if (b1_occ_max > 1 + EXTRA) begin errors++; $display("FAIL bub1_occ_max got %0d want <=%0d", b1_occ_max, 1 + EXTRA); end
      checks++; if (b8_occ_max > 8 + EXTRA) begin errors++; $display("FAIL bub8_occ_max got %0d want <=%0d", b8_occ_max, 8 + EXTRA); end
      checks++; if (b1_occ !== 4'd0 || b8_occ !== 4'd0) begin
         errors++; $display("FAIL bub_final_occ got %0d/%0d want 0/0", b1_occ, b8_occ);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_halt();
      test_async_reset();
      test_bubbles();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
